// File: rtl/axi_gpio_pkg.sv
// Shared types and constants for the AXI GPIO write slave: FSM encoding, register offsets, BRESP codes.
// No logic of its own; the address/offset decode helper is pure combinational.
package axi_gpio_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR_ONLY = 3'd1,
    ST_DATA_ONLY = 3'd2,
    ST_DRAIN     = 3'd3,
    ST_RESP      = 3'd4
  } state_t;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hE000A000;

  localparam logic [11:0] OFF_GPIO_OUT  = 12'h040;
  localparam logic [11:0] OFF_GPIO_DIRM = 12'h204;
  localparam logic [11:0] OFF_GPIO_OEN  = 12'h208;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // True when addr hits one of the three mapped, word-aligned registers inside the 4 KiB window.
  function automatic logic addr_hit(input logic [31:0] addr, input logic [19:0] base_page);
    logic off_ok;
    off_ok = (addr[11:0] == OFF_GPIO_OUT) || (addr[11:0] == OFF_GPIO_DIRM) ||
             (addr[11:0] == OFF_GPIO_OEN);
    return (addr[31:12] == base_page) && off_ok && (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/axi_strb_reg.sv
// One 32-bit register with per-byte write strobes and synchronous active-high reset.
// Write takes effect on the enabling edge; reset has priority over write.
module axi_strb_reg (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [3:0]  strb_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] q_o
);

  logic [31:0] data_q;
  logic [31:0] data_d;

  always_comb begin
    data_d = data_q;
    for (int i = 0; i < 4; i++) begin
      if (we_i && strb_i[i]) data_d[8*i +: 8] = wdata_i[8*i +: 8];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) data_q <= '0;
    else       data_q <= data_d;
  end

  assign q_o = data_q;

endmodule

// File: rtl/axi_gpio_wr_slave.sv
// Single-outstanding AXI4 write slave for three GPIO registers; commits on the edge completing AW+W, bvalid the cycle after.
// Backpressure: AW/W stall (ready low) while a response waits for bready; only single-beat, mapped, aligned writes succeed.
module axi_gpio_wr_slave
  import axi_gpio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
  input  logic        s00_axi_aclk,
  input  logic        s00_axi_areset,
  input  logic [3:0]  s00_axi_awid,
  input  logic [31:0] s00_axi_awaddr,
  input  logic [7:0]  s00_axi_awlen,
  input  logic [2:0]  s00_axi_awsize,
  input  logic        s00_axi_awvalid,
  output logic        s00_axi_awready,
  input  logic [31:0] s00_axi_wdata,
  input  logic [3:0]  s00_axi_wstrb,
  input  logic        s00_axi_wlast,
  input  logic        s00_axi_wvalid,
  output logic        s00_axi_wready,
  output logic [3:0]  s00_axi_bid,
  output logic [1:0]  s00_axi_bresp,
  output logic        s00_axi_bvalid,
  input  logic        s00_axi_bready,
  output logic [31:0] gpio_dirm,
  output logic [31:0] gpio_oen,
  output logic [31:0] gpio_out,
  output logic [15:0] wr_count
);

  state_t      state_q;
  logic [3:0]  awid_q;
  logic [31:0] awaddr_q;
  logic [7:0]  awlen_q;
  logic [2:0]  awsize_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        wlast_q;
  logic [3:0]  bid_q;
  logic [1:0]  bresp_q;
  logic        bvalid_q;
  logic [15:0] wr_count_q;
  logic [15:0] wr_count_d;

  logic        aw_hs;
  logic        w_hs;
  logic        complete;
  logic        txn_ok;
  logic        commit;
  logic [3:0]  sel_awid;
  logic [31:0] sel_awaddr;
  logic [7:0]  sel_awlen;
  logic [2:0]  sel_awsize;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_wstrb;
  logic        sel_wlast;
  logic [1:0]  resp_code;

  assign s00_axi_awready = !s00_axi_areset &&
                           ((state_q == ST_IDLE) || (state_q == ST_DATA_ONLY));
  assign s00_axi_wready  = !s00_axi_areset &&
                           ((state_q == ST_IDLE) || (state_q == ST_ADDR_ONLY) ||
                            (state_q == ST_DRAIN));

  assign aw_hs = s00_axi_awvalid && s00_axi_awready;
  assign w_hs  = s00_axi_wvalid  && s00_axi_wready;

  // Merge whichever half of the transaction was latched earlier with the half arriving now.
  always_comb begin
    complete   = 1'b0;
    sel_awid   = awid_q;
    sel_awaddr = awaddr_q;
    sel_awlen  = awlen_q;
    sel_awsize = awsize_q;
    sel_wdata  = wdata_q;
    sel_wstrb  = wstrb_q;
    sel_wlast  = wlast_q;
    if (state_q == ST_IDLE || state_q == ST_DATA_ONLY) begin
      sel_awid   = s00_axi_awid;
      sel_awaddr = s00_axi_awaddr;
      sel_awlen  = s00_axi_awlen;
      sel_awsize = s00_axi_awsize;
    end
    if (state_q == ST_IDLE || state_q == ST_ADDR_ONLY) begin
      sel_wdata = s00_axi_wdata;
      sel_wstrb = s00_axi_wstrb;
      sel_wlast = s00_axi_wlast;
    end
    case (state_q)
      ST_IDLE:      complete = aw_hs && w_hs;
      ST_ADDR_ONLY: complete = w_hs;
      ST_DATA_ONLY: complete = aw_hs;
      default:      complete = 1'b0;
    endcase
  end

  assign txn_ok = addr_hit(sel_awaddr, BASE_ADDR[31:12]) && (sel_awlen == 8'd0) &&
                  (sel_awsize <= 3'b010) && sel_wlast;
  assign commit     = complete && txn_ok && !s00_axi_areset;
  assign resp_code  = txn_ok ? RESP_OKAY : RESP_SLVERR;
  assign wr_count_d = commit ? wr_count_q + 16'd1 : wr_count_q;

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      state_q    <= ST_IDLE;
      awid_q     <= '0;
      awaddr_q   <= '0;
      awlen_q    <= '0;
      awsize_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wlast_q    <= 1'b0;
      bid_q      <= '0;
      bresp_q    <= RESP_OKAY;
      bvalid_q   <= 1'b0;
      wr_count_q <= '0;
    end else begin
      wr_count_q <= wr_count_d;
      case (state_q)
        ST_IDLE: begin
          if (aw_hs && w_hs) begin
            bid_q   <= s00_axi_awid;
            bresp_q <= resp_code;
            if (s00_axi_wlast) begin
              state_q  <= ST_RESP;
              bvalid_q <= 1'b1;
            end else begin
              state_q <= ST_DRAIN;
            end
          end else if (aw_hs) begin
            awid_q   <= s00_axi_awid;
            awaddr_q <= s00_axi_awaddr;
            awlen_q  <= s00_axi_awlen;
            awsize_q <= s00_axi_awsize;
            state_q  <= ST_ADDR_ONLY;
          end else if (w_hs) begin
            wdata_q <= s00_axi_wdata;
            wstrb_q <= s00_axi_wstrb;
            wlast_q <= s00_axi_wlast;
            state_q <= ST_DATA_ONLY;
          end
        end
        ST_ADDR_ONLY: begin
          if (w_hs) begin
            bid_q   <= awid_q;
            bresp_q <= resp_code;
            if (s00_axi_wlast) begin
              state_q  <= ST_RESP;
              bvalid_q <= 1'b1;
            end else begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DATA_ONLY: begin
          if (aw_hs) begin
            bid_q   <= s00_axi_awid;
            bresp_q <= resp_code;
            if (wlast_q) begin
              state_q  <= ST_RESP;
              bvalid_q <= 1'b1;
            end else begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (w_hs && s00_axi_wlast) begin
            state_q  <= ST_RESP;
            bvalid_q <= 1'b1;
          end
        end
        ST_RESP: begin
          if (s00_axi_bready) begin
            state_q  <= ST_IDLE;
            bvalid_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          bvalid_q <= 1'b0;
        end
      endcase
    end
  end

  axi_strb_reg u_reg_out (
    .clk_i   (s00_axi_aclk),
    .rst_i   (s00_axi_areset),
    .we_i    (commit && (sel_awaddr[11:0] == OFF_GPIO_OUT)),
    .strb_i  (sel_wstrb),
    .wdata_i (sel_wdata),
    .q_o     (gpio_out)
  );

  axi_strb_reg u_reg_dirm (
    .clk_i   (s00_axi_aclk),
    .rst_i   (s00_axi_areset),
    .we_i    (commit && (sel_awaddr[11:0] == OFF_GPIO_DIRM)),
    .strb_i  (sel_wstrb),
    .wdata_i (sel_wdata),
    .q_o     (gpio_dirm)
  );

  axi_strb_reg u_reg_oen (
    .clk_i   (s00_axi_aclk),
    .rst_i   (s00_axi_areset),
    .we_i    (commit && (sel_awaddr[11:0] == OFF_GPIO_OEN)),
    .strb_i  (sel_wstrb),
    .wdata_i (sel_wdata),
    .q_o     (gpio_oen)
  );

  assign s00_axi_bid    = bid_q;
  assign s00_axi_bresp  = bresp_q;
  assign s00_axi_bvalid = bvalid_q;
  assign wr_count       = wr_count_q;

endmodule

// File: tb/tb_axi_gpio_wr_slave.sv
// Directed bench for axi_gpio_wr_slave: ordering of AW/W, B backpressure, error responses, strobes and reset.
module tb_axi_gpio_wr_slave;

  logic        clk = 1'b0;
  logic        areset;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] gpio_dirm;
  logic [31:0] gpio_oen;
  logic [31:0] gpio_out;
  logic [15:0] wr_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axi_gpio_wr_slave #(.BASE_ADDR(32'hE000A000)) dut (
    .s00_axi_aclk    (clk),
    .s00_axi_areset  (areset),
    .s00_axi_awid    (awid),
    .s00_axi_awaddr  (awaddr),
    .s00_axi_awlen   (awlen),
    .s00_axi_awsize  (awsize),
    .s00_axi_awvalid (awvalid),
    .s00_axi_awready (awready),
    .s00_axi_wdata   (wdata),
    .s00_axi_wstrb   (wstrb),
    .s00_axi_wlast   (wlast),
    .s00_axi_wvalid  (wvalid),
    .s00_axi_wready  (wready),
    .s00_axi_bid     (bid),
    .s00_axi_bresp   (bresp),
    .s00_axi_bvalid  (bvalid),
    .s00_axi_bready  (bready),
    .gpio_dirm       (gpio_dirm),
    .gpio_oen        (gpio_oen),
    .gpio_out        (gpio_out),
    .wr_count        (wr_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    awid = id; awaddr = addr; awlen = len; awsize = 3'b010; awvalid = 1'b1;
  endtask

  task automatic drive_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
    wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
  endtask

  task automatic idle_bus();
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic b_accept(input string tag);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk({tag, "_bvalid_drop"}, {31'd0, bvalid}, 32'd0);
  endtask

  initial begin
    areset = 1'b1; bready = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;

    // Reset state
    tick();
    chk("rst_awready", {31'd0, awready}, 32'd0);
    chk("rst_wready", {31'd0, wready}, 32'd0);
    chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
    chk("rst_bid", {28'd0, bid}, 32'd0);
    chk("rst_bresp", {30'd0, bresp}, 32'd0);
    chk("rst_dirm", gpio_dirm, 32'd0);
    chk("rst_oen", gpio_oen, 32'd0);
    chk("rst_out", gpio_out, 32'd0);
    chk("rst_count", {16'd0, wr_count}, 32'd0);
    areset = 1'b0;
    tick();
    chk("idle_awready", {31'd0, awready}, 32'd1);
    chk("idle_wready", {31'd0, wready}, 32'd1);

    // AW and W together to gpio_dirm
    drive_aw(4'd0, 32'hE000A204, 8'd0);
    drive_w(32'h0000FE01, 4'hF, 1'b1);
    tick();
    idle_bus();
    chk("t1_dirm", gpio_dirm, 32'h0000FE01);
    chk("t1_bvalid", {31'd0, bvalid}, 32'd1);
    chk("t1_bid", {28'd0, bid}, 32'd0);
    chk("t1_bresp", {30'd0, bresp}, 32'd0);
    chk("t1_count", {16'd0, wr_count}, 32'd1);
    b_accept("t1");

    // AW first, W three cycles later, to gpio_oen
    drive_aw(4'd1, 32'hE000A208, 8'd0);
    tick();
    idle_bus();
    chk("t2_awready_wait0", {31'd0, awready}, 32'd0);
    tick();
    chk("t2_awready_wait1", {31'd0, awready}, 32'd0);
    tick();
    chk("t2_awready_wait2", {31'd0, awready}, 32'd0);
    chk("t2_oen_before", gpio_oen, 32'd0);
    drive_w(32'h0000FE01, 4'hF, 1'b1);
    tick();
    idle_bus();
    chk("t2_oen", gpio_oen, 32'h0000FE01);
    chk("t2_bvalid", {31'd0, bvalid}, 32'd1);
    chk("t2_bid", {28'd0, bid}, 32'd1);
    chk("t2_bresp", {30'd0, bresp}, 32'd0);
    chk("t2_count", {16'd0, wr_count}, 32'd2);
    b_accept("t2");

    // W first, AW two cycles later, to gpio_out
    drive_w(32'h00000001, 4'hF, 1'b1);
    tick();
    idle_bus();
    chk("t3_wready_wait", {31'd0, wready}, 32'd0);
    chk("t3_awready_wait", {31'd0, awready}, 32'd1);
    tick();
    drive_aw(4'd2, 32'hE000A040, 8'd0);
    tick();
    idle_bus();
    chk("t3_out", gpio_out, 32'h00000001);
    chk("t3_bid", {28'd0, bid}, 32'd2);
    chk("t3_bresp", {30'd0, bresp}, 32'd0);
    chk("t3_count", {16'd0, wr_count}, 32'd3);

    // bready held low while a new AW waits
    drive_aw(4'd3, 32'hE000A204, 8'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_bvalid_hold", {31'd0, bvalid}, 32'd1);
      chk("t4_bid_hold", {28'd0, bid}, 32'd2);
      chk("t4_awready_hold", {31'd0, awready}, 32'd0);
      chk("t4_wready_hold", {31'd0, wready}, 32'd0);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("t4_bvalid_done", {31'd0, bvalid}, 32'd0);
    chk("t4_awready_after", {31'd0, awready}, 32'd1);
    tick();
    idle_bus();
    chk("t4_aw_taken", {31'd0, awready}, 32'd0);

    // Partial strobe onto gpio_dirm
    drive_w(32'hFFFFFFFF, 4'b0011, 1'b1);
    tick();
    idle_bus();
    chk("t5_dirm_strb", gpio_dirm, 32'h0000FFFF);
    chk("t5_bid", {28'd0, bid}, 32'd3);
    chk("t5_count", {16'd0, wr_count}, 32'd4);
    b_accept("t5");

    // Unmapped offset
    drive_aw(4'd4, 32'hE000A300, 8'd0);
    drive_w(32'hDEADBEEF, 4'hF, 1'b1);
    tick();
    idle_bus();
    chk("e1_bvalid", {31'd0, bvalid}, 32'd1);
    chk("e1_bresp", {30'd0, bresp}, 32'd2);
    chk("e1_bid", {28'd0, bid}, 32'd4);
    chk("e1_dirm", gpio_dirm, 32'h0000FFFF);
    chk("e1_oen", gpio_oen, 32'h0000FE01);
    chk("e1_out", gpio_out, 32'h00000001);
    chk("e1_count", {16'd0, wr_count}, 32'd4);
    b_accept("e1");

    // Four-beat burst: all beats drained, then SLVERR
    drive_aw(4'd5, 32'hE000A040, 8'd3);
    drive_w(32'hFFFFFFFF, 4'hF, 1'b0);
    tick();
    awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("e2_drain_wready", {31'd0, wready}, 32'd1);
      tick();
      chk("e2_drain_bvalid", {31'd0, bvalid}, 32'd0);
    end
    wlast = 1'b1;
    tick();
    idle_bus();
    chk("e2_bvalid", {31'd0, bvalid}, 32'd1);
    chk("e2_bresp", {30'd0, bresp}, 32'd2);
    chk("e2_bid", {28'd0, bid}, 32'd5);
    chk("e2_out", gpio_out, 32'h00000001);
    chk("e2_count", {16'd0, wr_count}, 32'd4);
    b_accept("e2");

    // Reset pulsed while a response is pending
    drive_aw(4'd6, 32'hE000A040, 8'd0);
    drive_w(32'hA5A5A5A5, 4'hF, 1'b1);
    tick();
    idle_bus();
    chk("r_pre_out", gpio_out, 32'hA5A5A5A5);
    chk("r_pre_bvalid", {31'd0, bvalid}, 32'd1);
    areset = 1'b1;
    tick();
    chk("r_bvalid", {31'd0, bvalid}, 32'd0);
    chk("r_awready", {31'd0, awready}, 32'd0);
    chk("r_dirm", gpio_dirm, 32'd0);
    chk("r_oen", gpio_oen, 32'd0);
    chk("r_out", gpio_out, 32'd0);
    chk("r_count", {16'd0, wr_count}, 32'd0);
    areset = 1'b0;
    tick();
    chk("r_idle_awready", {31'd0, awready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
